// File: rtl/type_pkg.sv
// Shared types for the load/store unit: bus widths, operation codes, FSM state
// and the captured memory-operation payload.
package type_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned BE_W     = 4;
    localparam int unsigned OPCODE_W = 7;

    typedef logic [XLEN-1:0]     MemAddrBus;
    typedef logic [XLEN-1:0]     MemBus;
    typedef logic [XLEN-1:0]     RegBus;
    typedef logic [REG_AW-1:0]   RegAddrBus;
    typedef logic [OPCODE_W-1:0] OpcodeWide;
    typedef logic [BE_W-1:0]     ByteEn;

    localparam MemBus     ZeroWord = '0;
    localparam RegAddrBus ZeroReg  = '0;

    typedef enum logic [3:0] {
        EX_NOP, EX_ALU,
        EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU,
        EX_SB, EX_SH, EX_SW
    } ExCode;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_RESP} LsuState;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} LsuSize;

    // Everything about a memory op that must survive after issue
    typedef struct packed {
        logic      is_store;
        LsuSize    size;
        logic      sign_ext;
        logic [1:0] lane;
        logic      reg_we;
        RegAddrBus rd;
        MemAddrBus addr;
        ByteEn     be;
        MemBus     wdata;
    } LsuOp;

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it to register width.
module lsu_load_align
    import type_pkg::*;
(
    input  MemBus      rdata,
    input  logic [1:0] lane,
    input  LsuSize     size,
    input  logic       sign_ext,
    output RegBus      data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues data-bus requests, stalls the pipeline
// until the access completes, and registers the MEM/WB writeback.
module mem_lsu
    import type_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      valid_i,
    input  ExCode     ex_code_i,
    input  OpcodeWide opcode_i,
    input  MemAddrBus mem_raddr_i,
    input  MemAddrBus mem_waddr_i,
    input  MemBus     mem_wdata_i,
    input  logic      reg_we_i,
    input  RegAddrBus reg_waddr_i,
    input  RegBus     reg_wdata_i,
    output logic      dbus_req_o,
    output logic      dbus_we_o,
    output MemAddrBus dbus_addr_o,
    output ByteEn     dbus_be_o,
    output MemBus     dbus_wdata_o,
    input  logic      dbus_gnt_i,
    input  logic      dbus_rvalid_i,
    input  MemBus     dbus_rdata_i,
    output logic      stall_o,
    output logic      misalign_o,
    output logic      wb_we_o,
    output RegAddrBus wb_waddr_o,
    output RegBus     wb_wdata_o
);

    LsuState   state;
    LsuOp      op;
    LsuOp      new_op;
    logic      is_load;
    logic      is_store;
    logic      is_mem;
    logic      misaligned;
    logic      issue;
    MemAddrBus acc_addr;
    RegBus     load_data;
    logic      unused_opcode;

    assign unused_opcode = ^opcode_i;

    lsu_load_align u_align (
        .rdata    (dbus_rdata_i),
        .lane     (op.lane),
        .size     (op.size),
        .sign_ext (op.sign_ext),
        .data     (load_data)
    );

    // Decode the incoming slot and build the op that would be issued this cycle
    always_comb begin
        is_load         = 1'b0;
        is_store        = 1'b0;
        new_op          = '0;
        new_op.size     = SZ_WORD;
        case (ex_code_i)
            EX_LB:   begin is_load = 1'b1;  new_op.size = SZ_BYTE; new_op.sign_ext = 1'b1; end
            EX_LH:   begin is_load = 1'b1;  new_op.size = SZ_HALF; new_op.sign_ext = 1'b1; end
            EX_LW:   begin is_load = 1'b1;  new_op.size = SZ_WORD; end
            EX_LBU:  begin is_load = 1'b1;  new_op.size = SZ_BYTE; end
            EX_LHU:  begin is_load = 1'b1;  new_op.size = SZ_HALF; end
            EX_SB:   begin is_store = 1'b1; new_op.size = SZ_BYTE; end
            EX_SH:   begin is_store = 1'b1; new_op.size = SZ_HALF; end
            EX_SW:   begin is_store = 1'b1; new_op.size = SZ_WORD; end
            default: ;
        endcase
        acc_addr        = is_store ? mem_waddr_i : mem_raddr_i;
        is_mem          = is_load | is_store;
        misaligned      = ((new_op.size == SZ_HALF) && acc_addr[0]) ||
                          ((new_op.size == SZ_WORD) && (acc_addr[1:0] != 2'b00));
        issue           = !rst && (state == LSU_IDLE) && valid_i && is_mem && !misaligned;

        new_op.is_store = is_store;
        new_op.lane     = acc_addr[1:0];
        new_op.reg_we   = reg_we_i;
        new_op.rd       = reg_waddr_i;
        new_op.addr     = {acc_addr[31:2], 2'b00};
        case (new_op.size)
            SZ_BYTE: begin
                new_op.be    = ByteEn'(4'b0001) << acc_addr[1:0];
                new_op.wdata = {4{mem_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                new_op.be    = ByteEn'(4'b0011) << acc_addr[1:0];
                new_op.wdata = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                new_op.be    = 4'b1111;
                new_op.wdata = mem_wdata_i;
            end
        endcase
    end

    // Bus drive and stall: the request appears in the issue cycle, then is
    // replayed from the captured op until granted
    always_comb begin
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = ZeroWord;
        dbus_be_o    = '0;
        dbus_wdata_o = ZeroWord;
        stall_o      = 1'b0;
        if (issue) begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = new_op.is_store;
            dbus_addr_o  = new_op.addr;
            dbus_be_o    = new_op.be;
            dbus_wdata_o = new_op.wdata;
            stall_o      = !(new_op.is_store && dbus_gnt_i);
        end else if (!rst && state == LSU_REQ) begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = op.is_store;
            dbus_addr_o  = op.addr;
            dbus_be_o    = op.be;
            dbus_wdata_o = op.wdata;
            stall_o      = !(op.is_store && dbus_gnt_i);
        end else if (!rst && state == LSU_RESP) begin
            stall_o      = !dbus_rvalid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LSU_IDLE;
            op         <= '0;
            wb_we_o    <= 1'b0;
            wb_waddr_o <= ZeroReg;
            wb_wdata_o <= ZeroWord;
            misalign_o <= 1'b0;
        end else begin
            wb_we_o    <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (issue) begin
                        op <= new_op;
                        if (!dbus_gnt_i)
                            state <= LSU_REQ;
                        else if (!new_op.is_store)
                            state <= LSU_RESP;
                    end else if (valid_i && is_mem) begin
                        misalign_o <= 1'b1;
                    end else if (valid_i) begin
                        wb_we_o    <= reg_we_i && (reg_waddr_i != ZeroReg);
                        wb_waddr_o <= reg_waddr_i;
                        wb_wdata_o <= reg_wdata_i;
                    end
                end
                LSU_REQ: begin
                    if (dbus_gnt_i)
                        state <= op.is_store ? LSU_IDLE : LSU_RESP;
                end
                LSU_RESP: begin
                    if (dbus_rvalid_i) begin
                        state      <= LSU_IDLE;
                        wb_we_o    <= op.reg_we && (op.rd != ZeroReg);
                        wb_waddr_o <= op.rd;
                        wb_wdata_o <= load_data;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule
